// File: rtl/clock_pkg.sv
// Shared constants for the clock front end.
// Holds button channel indices, channel count and default timing values
// used by button_conditioner and button_channel.
package clock_pkg;

  localparam int unsigned NUM_BTN   = 6;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_MODE  = 4;
  localparam int unsigned BTN_SET   = 5;

  // Simulation-friendly timing; silicon builds override DEBOUNCE_CYCLES.
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned REPEAT_DELAY_DEF    = 50;
  localparam int unsigned REPEAT_RATE_DEF     = 10;

  // Auto-repeat on up and down only.
  localparam logic [NUM_BTN-1:0] REPEAT_MASK_DEF = 6'b000011;

endpackage

// File: rtl/button_channel.sv
// Single button channel: synchroniser, debounce, press edge detect and
// optional auto-repeat.
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous active-high reset
//   i_btn   - raw asynchronous button input, 1 = pressed
//   o_level - debounced (stable) level
//   o_pulse - one-cycle press / repeat pulse
module button_channel #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RpW = $clog2(REPEAT_DELAY + 1);

  localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RpW-1:0] RpLast   = RpW'(REPEAT_DELAY - 1);
  localparam logic [RpW-1:0] RpReload = RpW'(REPEAT_DELAY - REPEAT_RATE);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  logic [RpW-1:0]         rp_cnt_q, rp_cnt_d;
  logic                   stable_q, stable_d;
  logic                   pulse_q, pulse_d;
  logic                   synced;
  logic                   rise;
  logic                   repeat_hit;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
  assign synced = sync_q[SYNC_STAGES-1];

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // mismatching edges; any matching edge restarts the count.
  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (db_cnt_q == DbLast) begin
        stable_d = synced;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign rise = stable_d & ~stable_q;

  // Repeat counter runs only while the level stays high. Using stable_d
  // suppresses any repeat on the edge where the level falls. The >= compare
  // plus reload keeps the counter bounded, so it can never wrap.
  always_comb begin
    rp_cnt_d   = '0;
    repeat_hit = 1'b0;
    if (REPEAT_EN && stable_d && !rise) begin
      if (rp_cnt_q >= RpLast) begin
        repeat_hit = 1'b1;
        rp_cnt_d   = RpReload;
      end else begin
        rp_cnt_d = rp_cnt_q + 1'b1;
      end
    end
  end

  assign pulse_d = rise | repeat_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      rp_cnt_q <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      rp_cnt_q <= rp_cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  assign o_level = stable_q;
  assign o_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Six-channel button front end for the clock top level.
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous active-high reset
//   i_btn   - raw button inputs, 1 = pressed
//   o_level - debounced level per channel (o_level[BTN_SET] drives set)
//   o_pulse - one-cycle press / repeat pulse per channel
module button_conditioner #(
  parameter int unsigned       NUM_BTN         = clock_pkg::NUM_BTN,
  parameter int unsigned       SYNC_STAGES     = clock_pkg::SYNC_STAGES_DEF,
  parameter int unsigned       DEBOUNCE_CYCLES = clock_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int unsigned       REPEAT_DELAY    = clock_pkg::REPEAT_DELAY_DEF,
  parameter int unsigned       REPEAT_RATE     = clock_pkg::REPEAT_RATE_DEF,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK    = clock_pkg::REPEAT_MASK_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_pulse
);

  import clock_pkg::*;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (REPEAT_MASK[g])
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (i_btn[g]),
      .o_level(o_level[g]),
      .o_pulse(o_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios with
// literal expectations plus randomized stimulus against a window-based model.
module tb_button_conditioner;

  localparam int NB    = 6;
  localparam int SS    = 2;
  localparam int DB    = 4;
  localparam int DELAY = 50;
  localparam int RATE  = 10;
  localparam logic [NB-1:0] MASK = 6'b000011;

  logic          clk;
  logic          i_rst;
  logic [NB-1:0] i_btn;
  logic [NB-1:0] o_level;
  logic [NB-1:0] o_pulse;

  int checks   = 0;
  int failures = 0;

  button_conditioner u_dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_btn  (i_btn),
    .o_level(o_level),
    .o_pulse(o_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  logic [NB-1:0] raw_h [64];
  int            n        = 0;
  int            last_rst = 0;
  bit            started  = 0;
  logic [NB-1:0] m_stable = '0;
  logic [NB-1:0] m_pulse  = '0;
  int            press_edge [NB];

  // Synchroniser output after edge m: raw sampled SS-1 edges earlier,
  // or 0 if that sample was taken at or before the last reset edge.
  function automatic logic synced(input int m, input int ch);
    int j;
    j = m - (SS - 1);
    if (j > last_rst) return raw_h[j % 64][ch];
    return 1'b0;
  endfunction

  initial begin
    logic          cur_rst;
    logic [NB-1:0] prev;
    bit            flip;
    int            t;
    forever begin
      @(posedge clk);
      n++;
      raw_h[n % 64] = i_btn;
      cur_rst       = i_rst;
      #1;
      if (cur_rst) begin
        started  = 1;
        last_rst = n;
        m_stable = '0;
        m_pulse  = '0;
      end else if (started) begin
        prev    = m_stable;
        m_pulse = '0;
        for (int ch = 0; ch < NB; ch++) begin
          // New level accepted when the previous DB synced values all differ.
          flip = (n - DB >= last_rst);
          for (int m = n - DB; m < n; m++)
            if (flip && synced(m, ch) == prev[ch]) flip = 0;
          if (flip) m_stable[ch] = ~prev[ch];
          if (m_stable[ch] && !prev[ch]) begin
            press_edge[ch] = n;
            m_pulse[ch]    = 1'b1;
          end else if (m_stable[ch] && prev[ch] && MASK[ch]) begin
            t = n - press_edge[ch];
            if (t >= DELAY && ((t - DELAY) % RATE) == 0) m_pulse[ch] = 1'b1;
          end
        end
      end
      if (started) begin
        checks++;
        if (o_level !== m_stable || o_pulse !== m_pulse) begin
          failures++;
          $display("FAIL model_cmp edge=%0d level=%b exp=%b pulse=%b exp=%b",
                   n, o_level, m_stable, o_pulse, m_pulse);
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  int idx = 0;
  int k0;
  logic lv_last;
  int pq[$];
  int lq[$];

  task automatic tick();
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Tick n times, logging pulse and level-change offsets (relative to k0) of ch.
  task automatic run(input int cnt, input int ch);
    for (int i = 0; i < cnt; i++) begin
      tick();
      if (o_pulse[ch]) pq.push_back(idx - k0);
      if (o_level[ch] !== lv_last) begin
        lq.push_back(idx - k0);
        lv_last = o_level[ch];
      end
    end
  endtask

  task automatic begin_rec(input int ch);
    k0      = idx + 1;
    lv_last = o_level[ch];
    pq.delete();
    lq.delete();
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  initial begin
    int cd [NB];
    int exp_rep [6] = '{5, 55, 65, 75, 85, 95};

    i_rst = 1'b1;
    i_btn = '1;
    @(negedge clk);

    // Reset held 3 cycles with all buttons pressed.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_level", int'(o_level), 0);
      chk("rst_pulse", int'(o_pulse), 0);
    end
    i_rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("post_rst_pulse_%0d", i), int'(o_pulse), (i == 6) ? 'h3f : 0);
      if (i == 5) chk("post_rst_level_5", int'(o_level), 0);
      if (i == 6) chk("post_rst_level_6", int'(o_level), 'h3f);
    end
    i_btn = '0;
    repeat (12) tick();

    // Clean press of SET held 100 cycles.
    begin_rec(5);
    i_btn = 6'b100000;
    run(100, 5);
    i_btn = '0;
    run(12, 5);
    chk("set_npulse", pq.size(), 1);
    chk("set_pulse_at", qat(pq, 0), 5);
    chk("set_nlevel", lq.size(), 2);
    chk("set_rise_at", qat(lq, 0), 5);
    chk("set_fall_at", qat(lq, 1), 105);

    // Bounce on UP: toggles every 2 cycles for 20 cycles, then holds.
    begin_rec(0);
    for (int i = 0; i < 20; i++) begin
      i_btn[0] = ((i / 2) % 2) == 0;
      run(1, 0);
    end
    i_btn[0] = 1'b1;
    run(20, 0);
    i_btn[0] = 1'b0;
    run(12, 0);
    chk("bounce_npulse", pq.size(), 1);
    chk("bounce_pulse_at", qat(pq, 0), 25);
    chk("bounce_rise_at", qat(lq, 0), 25);
    chk("bounce_fall_at", qat(lq, 1), 45);

    // Short glitch on LEFT.
    begin_rec(2);
    i_btn[2] = 1'b1;
    run(3, 2);
    i_btn[2] = 1'b0;
    run(15, 2);
    chk("glitch_npulse", pq.size(), 0);
    chk("glitch_nlevel", lq.size(), 0);

    // Auto-repeat on UP held 97 cycles.
    begin_rec(0);
    i_btn[0] = 1'b1;
    run(97, 0);
    i_btn[0] = 1'b0;
    run(15, 0);
    chk("rep_npulse", pq.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rep_pulse_%0d", i), qat(pq, i), exp_rep[i]);
    chk("rep_rise_at", qat(lq, 0), 5);
    chk("rep_fall_at", qat(lq, 1), 102);

    // Simultaneous UP+DOWN press, reset mid-hold at press+30.
    begin_rec(0);
    i_btn = 6'b000011;
    run(6, 0);
    chk("simul_pulse", int'(o_pulse), 'h03);
    run(29, 0);
    i_rst = 1'b1;
    run(1, 0);
    chk("midrst_level", int'(o_level), 0);
    chk("midrst_pulse", int'(o_pulse), 0);
    i_rst = 1'b0;
    run(6, 0);
    chk("repress_pulse", int'(o_pulse), 'h03);
    run(50, 0);
    chk("repress_repeat", int'(o_pulse), 'h03);
    i_btn = '0;
    run(15, 0);
    chk("midrst_npulse", pq.size(), 3);
    chk("midrst_pulse2_at", qat(pq, 1), 41);

    // Randomized holds/bounces with occasional reset; model checks each cycle.
    for (int ch = 0; ch < NB; ch++) cd[ch] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NB; ch++) begin
        cd[ch]--;
        if (cd[ch] <= 0) begin
          i_btn[ch] = ~i_btn[ch];
          cd[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6)
                                              : $urandom_range(7, 120);
        end
      end
      i_rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    i_rst = 1'b0;
    i_btn = '0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end stage that feeds the clock top level its six user-button inputs (up, down, left, right, mode, set).
- Synchronises each raw, bouncy pad input to i_clk.
- Debounces it into a stable level.
- Produces one-cycle press pulses, with optional auto-repeat while a button is held.
- Outputs connect directly to the clock top level: o_pulse drives up/down/left/right/mode; o_level[BTN_SET] drives set.

Parameters:
NUM_BTN, 6, number of button channels.
SYNC_STAGES, 2, flip-flop synchroniser depth (>=2).
DEBOUNCE_CYCLES, 4, consecutive mismatching cycles required to accept a new level (sim value; silicon 1_000_000).
REPEAT_DELAY, 50, cycles from press pulse to first repeat pulse (>=2).
REPEAT_RATE, 10, cycles between subsequent repeat pulses (>=2).
REPEAT_MASK, 6'b000011, per-channel auto-repeat enable (up, down by default).

Ports:
i_clk  in  1  system clock.
i_rst  in  1  synchronous reset, active-high.
i_btn  in  NUM_BTN  raw asynchronous button inputs, 1 = pressed.
o_level  out  NUM_BTN  debounced level per channel.
o_pulse  out  NUM_BTN  one-cycle press / repeat pulse per channel.

Behaviour:
- Clocking and reset: one clock, i_rst synchronous and active-high.
  - While i_rst is sampled high, all synchroniser flops, stable levels, debounce and repeat counters, o_level and o_pulse clear to 0 at that edge.
  - Reset is honoured mid-operation: a bounce or repeat sequence in progress is abandoned.
  - A button held through reset is treated as a new press after reset.
- Channels are fully independent; simultaneous events on different channels are processed in parallel with no priority.
- Synchroniser: SYNC_STAGES-deep chain per channel.
  - Raw level sampled at edge k is visible as "synced" after edge k+SYNC_STAGES-1.
- Debounce, per channel: counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If synced == stable: counter <= 0.
  - Else: counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive mismatching edge: stable <= synced, counter <= 0.
  - Any single matching cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never change stable.
- Latency: a clean edge first sampled at edge k reaches o_level at edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES (k+5 at defaults). The same latency applies on release.
- o_level is the registered stable value.
- Press pulse: o_pulse[i] is high for exactly one cycle, registered, on the edge where stable goes 0->1. No pulse on release.
- Auto-repeat, only if REPEAT_MASK[i] = 1:
  - Repeat counter loads 0 on the press edge and increments each cycle while stable = 1.
  - When it reaches REPEAT_DELAY: emit a pulse and reload REPEAT_DELAY-REPEAT_RATE.
  - Pulses therefore occur at press+REPEAT_DELAY, +REPEAT_DELAY+REPEAT_RATE, and so on.
  - The counter clears on the edge stable falls. No repeat pulse is emitted on, or after, the edge where stable falls.
  - The counter saturates safely and never wraps to produce a spurious pulse.
  - Unmasked channels: one pulse per press regardless of hold length.
- No combinational path from i_btn to any output.

Decomposition:
- Shared package clock_pkg holds:
  - button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_MODE=4, BTN_SET=5;
  - NUM_BTN;
  - default timing constants.
- One sub-module, button_channel: synchroniser, debounce, edge detect and repeat for a single bit, with a REPEAT_EN parameter.
  - Instantiated NUM_BTN times via generate.
  - The top level only slices vectors and maps REPEAT_MASK bits.

Test Plan (defaults; k = first edge sampling the raw change):
- Reset: hold i_rst for 3 cycles with all i_btn = 1 -> o_level = 0 and o_pulse = 0 throughout; o_pulse = 6'b111111 for one cycle 6 edges after the last reset-high edge.
- Clean press of BTN_SET held 100 cycles -> o_level[5] rises at k+5; a single o_pulse[5] at k+5; no repeats. Release -> o_level[5] falls 5 edges after the release sample; no pulse.
- Bounce: i_btn[0] toggles every 2 cycles for 20 cycles, then stays 1 -> exactly one o_pulse[0], 5 edges after the settle sample; o_level[0] never toggles during the bounce.
- Glitch: i_btn[2] high for 3 cycles -> o_level[2] and o_pulse[2] stay 0.
- Auto-repeat: i_btn[0] high for 97 cycles -> o_pulse[0] at k+5, k+55, k+65, k+75, k+85, k+95 (6 pulses); o_level[0] falls at k+102; no further pulses.
- Simultaneous and mid-hold reset:
  - i_btn[0] and i_btn[1] rise together -> both pulse on the same edge.
  - i_rst for 1 cycle at press+30 -> outputs 0 next edge; repeat sequence restarts with a new press pulse 6 edges after reset.
